sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, number of data bits per frame.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-high (rst_n=1 resets).
REQ-004 SHALL have port: sin  input  1  serial data from upstream serializer, MSB first.
REQ-005 SHALL have port: sin_en  input  1  qualifies sin; bit sampled only when 1.
REQ-006 SHALL have port: sof  input  1  start-of-frame; marks the sampled bit as MSB of a new frame.
REQ-007 SHALL have port: dout  output  DATA_WIDTH  received parallel word.
REQ-008 SHALL have port: out_valid  output  1  dout holds an unconsumed word.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts dout when out_valid=1.
REQ-010 SHALL have port: ovr  output  1  one-cycle pulse, unconsumed word overwritten.
REQ-011 SHALL have port: frm_err  output  1  one-cycle pulse, frame aborted by early sof.
REQ-012 SHALL have port: perr  output  1  parity error flag, qualified by out_valid.

Function
REQ-013 FSM SHALL have states IDLE and SHIFT; bits with sin_en=0 are ignored in all states.
REQ-014 IDLE: sin_en=1 and sof=1 SHALL load sin as MSB, set bit count to 1, go to SHIFT; sin_en=1 with sof=0 is discarded.
REQ-015 SHIFT: each sin_en=1 bit SHALL shift left into shift register at LSB and increment count.
REQ-016 When the final frame bit is sampled, word SHALL transfer to dout, out_valid SHALL be 1 on the next cycle, FSM returns to IDLE.
REQ-017 A new frame SHALL be accepted in IDLE on the cycle immediately following the final bit (zero-gap back-to-back frames).
REQ-018 SHIFT with sof=1 and sin_en=1 SHALL discard partial frame, pulse frm_err for one cycle, restart with sin as MSB (count=1).
REQ-019 out_valid SHALL stay 1 and dout stable until a cycle with out_valid=1 and out_ready=1, then clear next cycle.
REQ-020 Word completion while out_valid=1 and out_ready=0 SHALL overwrite dout, keep out_valid=1, pulse ovr one cycle.
REQ-021 Word completion in the same cycle as an accepting handshake SHALL load new dout, keep out_valid=1, no ovr.
REQ-022 Bit counter SHALL be $clog2(DATA_WIDTH+2) bits wide and never wrap within a frame.

Reset
REQ-023 rst_n=1 SHALL force on the next edge: state IDLE, count 0, shift register 0, dout 0, out_valid 0, ovr 0, frm_err 0, perr 0.
REQ-024 Reset mid-frame SHALL discard the partial frame with no flag pulses; reset dominates all inputs.

Configuration
REQ-025 With SIPO_PARITY_EN defined, frame SHALL be DATA_WIDTH data bits plus one even-parity bit; perr SHALL be registered with dout and equal XOR of all data bits and parity bit.
REQ-026 Without SIPO_PARITY_EN, frame SHALL be DATA_WIDTH bits and perr SHALL be constant 0.

Structure
REQ-027 Package sipo_pkg SHALL hold the FSM state typedef and the counter-width localparam function.
REQ-028 One sub-module sipo_bitcnt (frame bit counter with clear/load/increment and last-bit flag) SHALL be instantiated; all else in sipo_rx.

Verification (DATA_WIDTH=8)
REQ-029 sof with bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=0 -> dout=8'hA5, out_valid=1 the cycle after bit 8, held until out_ready=1.
REQ-030 Same bits with sin_en=1 every other cycle -> dout=8'hA5, out_valid one cycle after last qualified bit.
REQ-031 sof re-asserted on bit 5 then bits of 8'h3C -> frm_err single pulse, dout=8'h3C.
REQ-032 Frames 8'h11 then 8'h22 back-to-back, out_ready=0 -> ovr single pulse, dout=8'h22, out_valid=1.
REQ-033 rst_n=1 after 4 bits, then full frame 8'h5A -> all outputs 0 during reset, then dout=8'h5A, no flags.
REQ-034 SIPO_PARITY_EN: 8'hA5 with parity 1 -> perr=1; with parity 0 -> perr=0.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the serial-in parallel-out receiver.
package sipo_pkg;

    // Receiver FSM: waiting for a start-of-frame, or collecting frame bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width that holds a full frame (data plus optional parity bit)
    // with headroom, so the count never wraps inside a frame.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 2);
    endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// Frame bit counter: clear / load-to-one / increment, with a flag that is
// high while the next qualified bit is the final bit of the frame.
module sipo_bitcnt #(
    parameter int CNT_W     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    // Count qualified bits of the current frame; reset and clear win over load.
    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver, MSB first, framed by sof, with a
// valid/ready output word, overwrite and frame-abort pulses.
// Optional build macro SIPO_PARITY_EN appends one even-parity bit per frame
// and drives perr; without it perr is tied low.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sin,
    input  logic                  sin_en,
    input  logic                  sof,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovr,
    output logic                  frm_err,
    output logic                  perr
);

`ifdef SIPO_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_LEN = DATA_WIDTH + PAR_W;
    localparam int SR_W      = FRAME_LEN - 1;
    localparam int CNT_W     = cnt_width(DATA_WIDTH);

    state_t                 state, state_nxt;
    logic                   start, shift, done, abort;
    logic                   last;
    logic [SR_W-1:0]        sreg;
    logic [FRAME_LEN-1:0]   word;

    // The final bit is never stored: the completed word is the register
    // contents with the bit being sampled appended at the LSB.
    assign word = {sreg, sin};

    sipo_bitcnt #(
        .CNT_W     (CNT_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (done),
        .load  (start | abort),
        .inc   (shift),
        .last  (last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-bit actions; unqualified bits do nothing anywhere.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (sin_en && sof) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_en) begin
                    if (sof) begin
                        abort = 1'b1;
                    end else if (last) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register: a new or restarted frame loads sin as the MSB.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sreg <= '0;
        end else if (start || abort) begin
            sreg <= SR_W'(sin);
        end else if (shift) begin
            sreg <= {sreg[SR_W-2:0], sin};
        end
    end

    // Output word, valid/ready handshake and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            dout      <= '0;
            out_valid <= 1'b0;
            ovr       <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            ovr     <= 1'b0;
            frm_err <= abort;
            if (done) begin
                dout      <= word[FRAME_LEN-1 -: DATA_WIDTH];
                out_valid <= 1'b1;
                ovr       <= out_valid && !out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // Even parity over data and parity bit, registered alongside dout.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            perr <= 1'b0;
        end else if (done) begin
            perr <= ^word;
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed scenarios plus a randomized run
// against a queue-based reference model of the frame rules.
module tb_sipo_rx;

`ifdef SIPO_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sin = 1'b0, sin_en = 1'b0, sof = 1'b0, out_ready = 1'b0;
    logic [7:0] dout;
    logic       out_valid, ovr, frm_err, perr;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    int         m_q[$];
    bit         m_in = 1'b0;
    logic [7:0] m_dout = '0;
    logic       m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;

    sipo_rx #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .sin_en    (sin_en),
        .sof       (sof),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr       (ovr),
        .frm_err   (frm_err),
        .perr      (perr)
    );

    always #5 clk = ~clk;

    // Frame rules: a frame is the run of qualified bits starting at a
    // qualified sof; it completes once FL bits are collected.
    task automatic model_update();
        bit         accept, complete;
        logic [7:0] d;
        bit         px;
        if (rst_n) begin
            m_q.delete(); m_in = 0; m_dout = '0; m_valid = 0;
            m_ovr = 0; m_ferr = 0; m_perr = 0;
            return;
        end
        m_ovr = 0; m_ferr = 0; complete = 0;
        accept = m_valid && out_ready;
        if (sin_en) begin
            if (sof) begin
                if (m_in) m_ferr = 1;
                m_q.delete(); m_q.push_back(int'(sin)); m_in = 1;
            end else if (m_in) begin
                m_q.push_back(int'(sin));
            end
        end
        if (m_in && m_q.size() == FL) begin
            d = '0; px = 0;
            for (int i = 0; i < FL; i++) begin
                if (i < 8) d = {d[6:0], m_q[i][0]};
                px = px ^ m_q[i][0];
            end
            complete = 1; m_in = 0; m_q.delete();
            if (m_valid && !accept) m_ovr = 1;
            m_dout = d; m_valid = 1;
`ifdef SIPO_PARITY_EN
            m_perr = px;
`endif
        end
        if (!complete && accept) m_valid = 0;
    endtask

    task automatic step(input logic r, input logic s, input logic e,
                        input logic f, input logic rdy);
        rst_n = r; sin = s; sin_en = e; sof = f; out_ready = rdy;
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic fbit(input logic [7:0] w, input logic p, input int i);
        logic [7:0] t;
        t = w;
        return (i < 8) ? t[7-i] : p;
    endfunction

    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < FL; i++) step(0, fbit(w, ^w, i), 1, i == 0, rdy);
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 0);
        n_chk++;
        if ({dout, out_valid, ovr, frm_err, perr} !== 12'h000)
            $display("FAIL reset_outputs: got %h required 000", {dout, out_valid, ovr, frm_err, perr});
        else n_pass++;
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_basic_a5();
        for (int i = 0; i < FL; i++) begin
            step(0, fbit(8'hA5, 1'b0, i), 1, i == 0, 0);
            if (i == FL - 2) begin
                n_chk++;
                if (out_valid !== 1'b0) $display("FAIL a5_early_valid: got %b required 0", out_valid);
                else n_pass++;
            end
        end
        n_chk++;
        if (out_valid !== 1'b1 || dout !== 8'hA5)
            $display("FAIL a5_word: got valid=%b dout=%h required 1 a5", out_valid, dout);
        else n_pass++;
        for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1), 0, $urandom_range(0, 1), 0);
        n_chk++;
        if (out_valid !== 1'b1 || dout !== 8'hA5)
            $display("FAIL a5_hold: got valid=%b dout=%h required 1 a5", out_valid, dout);
        else n_pass++;
        step(0, 0, 0, 0, 1);
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL a5_consume: got %b required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_gapped();
        for (int i = 0; i < FL; i++) begin
            step(0, fbit(8'hA5, 1'b0, i), 1, i == 0, 0);
            if (i != FL - 1) step(0, ~fbit(8'hA5, 1'b0, i), 0, 1, 0);
        end
        n_chk++;
        if (out_valid !== 1'b1 || dout !== 8'hA5)
            $display("FAIL gapped_word: got valid=%b dout=%h required 1 a5", out_valid, dout);
        else n_pass++;
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_frame_abort();
        for (int i = 0; i < 4; i++) step(0, fbit(8'hA5, 1'b0, i), 1, i == 0, 0);
        for (int i = 0; i < FL; i++) begin
            step(0, fbit(8'h3C, ^8'h3C, i), 1, i == 0, 0);
            if (i == 0) begin
                n_chk++;
                if (frm_err !== 1'b1) $display("FAIL abort_pulse: got %b required 1", frm_err);
                else n_pass++;
            end else if (i == 1) begin
                n_chk++;
                if (frm_err !== 1'b0) $display("FAIL abort_single: got %b required 0", frm_err);
                else n_pass++;
            end
        end
        n_chk++;
        if (out_valid !== 1'b1 || dout !== 8'h3C)
            $display("FAIL abort_word: got valid=%b dout=%h required 1 3c", out_valid, dout);
        else n_pass++;
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        send_word(8'h11, 0);
        n_chk++;
        if (ovr !== 1'b0 || dout !== 8'h11)
            $display("FAIL b2b_first: got ovr=%b dout=%h required 0 11", ovr, dout);
        else n_pass++;
        send_word(8'h22, 0);
        n_chk++;
        if (ovr !== 1'b1 || out_valid !== 1'b1 || dout !== 8'h22)
            $display("FAIL b2b_overwrite: got ovr=%b valid=%b dout=%h required 1 1 22", ovr, out_valid, dout);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_chk++;
        if (ovr !== 1'b0) $display("FAIL b2b_ovr_single: got %b required 0", ovr);
        else n_pass++;
        // completion on the same edge as an accepting handshake: no overwrite
        for (int i = 0; i < FL; i++) step(0, fbit(8'h33, ^8'h33, i), 1, i == 0, i == FL - 1);
        n_chk++;
        if (ovr !== 1'b0 || out_valid !== 1'b1 || dout !== 8'h33)
            $display("FAIL b2b_accept_load: got ovr=%b valid=%b dout=%h required 0 1 33", ovr, out_valid, dout);
        else n_pass++;
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 4; i++) step(0, fbit(8'hC3, 1'b0, i), 1, i == 0, 0);
        step(1, 1, 1, 1, 0);
        n_chk++;
        if ({dout, out_valid, ovr, frm_err, perr} !== 12'h000)
            $display("FAIL midrst_outputs: got %h required 000", {dout, out_valid, ovr, frm_err, perr});
        else n_pass++;
        send_word(8'h5A, 0);
        n_chk++;
        if (dout !== 8'h5A || out_valid !== 1'b1 || ovr !== 1'b0 || frm_err !== 1'b0 || perr !== 1'b0)
            $display("FAIL midrst_frame: got dout=%h valid=%b ovr=%b ferr=%b perr=%b required 5a 1 0 0 0",
                     dout, out_valid, ovr, frm_err, perr);
        else n_pass++;
        step(0, 0, 0, 0, 1);
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        for (int i = 0; i < FL; i++) step(0, fbit(8'hA5, 1'b1, i), 1, i == 0, 1);
        n_chk++;
        if (perr !== 1'b1 || dout !== 8'hA5) $display("FAIL parity_bad: got perr=%b dout=%h required 1 a5", perr, dout);
        else n_pass++;
        for (int i = 0; i < FL; i++) step(0, fbit(8'hA5, 1'b0, i), 1, i == 0, 1);
        n_chk++;
        if (perr !== 1'b0 || dout !== 8'hA5) $display("FAIL parity_good: got perr=%b dout=%h required 0 a5", perr, dout);
        else n_pass++;
        step(0, 0, 0, 0, 1);
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0), $urandom_range(0, 1));
            n_chk++;
            if ({dout, out_valid, ovr, frm_err, perr} !== {m_dout, m_valid, m_ovr, m_ferr, m_perr})
                $display("FAIL random_c%0d: got dout=%h v=%b ovr=%b ferr=%b perr=%b required %h %b %b %b %b",
                         c, dout, out_valid, ovr, frm_err, perr, m_dout, m_valid, m_ovr, m_ferr, m_perr);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_gapped();
        test_frame_abort();
        test_back_to_back();
        test_reset_midframe();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
